// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
package mips_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/mips_hazard_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: increment unless already saturated
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mips_hazard_unit.sv
// Stall/flush/forwarding controller for the 5-stage MIPS pipeline.
// Control outputs are Mealy (state plus this cycle's pipeline status).
module mips_hazard_unit
  import mips_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int LU_STALL_CYC = 1,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_W        = 16
) (
  input  logic              clk_CPU,
  input  logic              rst_CPU,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              redirect,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              id_ex_bubble,
  output logic              ex_mem_stall,
  output logic              mem_wb_bubble,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int LU_W   = 3;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [REG_AW-1:0] RZ      = REG_AW'(REG_ZERO);
  localparam logic [LU_W-1:0]   LU_LAST = LU_W'(LU_STALL_CYC - 1);
  localparam logic [WAIT_W-1:0] WAIT_TO = WAIT_W'(MEM_TIMEOUT);

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input logic [REG_AW-1:0] mrd, input logic mwr,
                                         input logic [REG_AW-1:0] wrd, input logic wwr);
    if (mwr && (mrd != RZ) && (mrd == src)) begin
      return FWD_MEM;
    end else if (wwr && (wrd != RZ) && (wrd == src)) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

  hz_state_e         state_q, state_d;
  logic [LU_W-1:0]   lu_cnt_q, lu_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic              lu_haz_s, mem_wait_s;
  logic              do_mem_s, do_flush_s, do_bub_s;

  // Operand forwarding; MEM result is younger so it beats WB
  always_comb begin
    if (rst_CPU) begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
    end else begin
      fwd_a = fwd_sel(ex_rs, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
      fwd_b = fwd_sel(ex_rt, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    end
  end

  // Hazard detection
  always_comb begin
    lu_haz_s   = ex_memread && (ex_rd != RZ) &&
                 ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));
    mem_wait_s = mem_req && !mem_ready;
  end

  // Next state and actions; priority is memory wait, then redirect, then load-use
  always_comb begin
    state_d    = state_q;
    lu_cnt_d   = lu_cnt_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    do_mem_s   = 1'b0;
    do_flush_s = 1'b0;
    do_bub_s   = 1'b0;
    if (rst_CPU) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_wait_s) begin
            do_mem_s   = 1'b1;
            state_d    = MEM_WAIT;
            wait_cnt_d = WAIT_W'(1);
          end else if (redirect) begin
            do_flush_s = 1'b1;
          end else if (lu_haz_s) begin
            do_bub_s = 1'b1;
            if (LU_STALL_CYC > 1) begin
              state_d  = LU_STALL;
              lu_cnt_d = LU_W'(1);
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = RUN;
          end
        end
        LU_STALL: begin
          if (mem_wait_s) begin
            do_mem_s   = 1'b1;
            state_d    = MEM_WAIT;
            wait_cnt_d = WAIT_W'(1);
          end else if (redirect) begin
            do_flush_s = 1'b1;
            state_d    = RUN;
          end else begin
            do_bub_s = 1'b1;
            if (lu_cnt_q == LU_LAST) begin
              state_d = RUN;
            end else begin
              lu_cnt_d = lu_cnt_q + LU_W'(1);
            end
          end
        end
        MEM_WAIT: begin
          // Release cycle: the held access is done, so only redirect/load-use can act
          if (mem_ready || (wait_cnt_q == WAIT_TO)) begin
            state_d = RUN;
            if (!mem_ready) begin
              mem_err_d = 1'b1;
            end else begin
              mem_err_d = mem_err_q;
            end
            if (redirect) begin
              do_flush_s = 1'b1;
            end else if (lu_haz_s) begin
              do_bub_s = 1'b1;
              if (LU_STALL_CYC > 1) begin
                state_d  = LU_STALL;
                lu_cnt_d = LU_W'(1);
              end else begin
                state_d = RUN;
              end
            end else begin
              state_d = RUN;
            end
          end else begin
            do_mem_s   = 1'b1;
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // FSM state and sticky error
  always_ff @(posedge clk_CPU or posedge rst_CPU) begin
    if (rst_CPU) begin
      state_q    <= RUN;
      lu_cnt_q   <= '0;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lu_cnt_q   <= lu_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign pc_stall      = do_mem_s | do_bub_s;
  assign if_id_stall   = do_mem_s | do_bub_s;
  assign id_ex_bubble  = do_bub_s;
  assign ex_mem_stall  = do_mem_s;
  assign mem_wb_bubble = do_mem_s;
  assign if_id_flush   = do_flush_s;
  assign id_ex_flush   = do_flush_s;
  assign ex_mem_flush  = do_flush_s;
  assign mem_err       = mem_err_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_CPU),
    .rst_i   (rst_CPU),
    .inc_i   (pc_stall),
    .count_o (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_CPU),
    .rst_i   (rst_CPU),
    .inc_i   (if_id_flush),
    .count_o (flush_cnt)
  );

endmodule

// File: tb/tb_mips_hazard_unit.sv
// Bench for mips_hazard_unit: two instances (1-cycle and 3-cycle load-use, 2-bit and 16-bit counters)
// share stimulus and are compared each cycle against a behavioural model.
module tb_mips_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs, id_uses_rt, ex_memread, mem_regwrite, wb_regwrite;
  logic       mem_req, mem_ready, redirect;

  logic        pc_a, ifid_a, bub_a, ems_a, mwb_a, f1_a, f2_a, f3_a, err_a;
  logic [1:0]  fa_a, fb_a, sc_a, fc_a;
  logic        pc_b, ifid_b, bub_b, ems_b, mwb_b, f1_b, f2_b, f3_b, err_b;
  logic [1:0]  fa_b, fb_b;
  logic [15:0] sc_b, fc_b;

  mips_hazard_unit #(.REG_AW(5), .LU_STALL_CYC(1), .MEM_TIMEOUT(16), .CNT_W(2)) u_dut_a (
    .clk_CPU(clk), .rst_CPU(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .mem_req(mem_req), .mem_ready(mem_ready),
    .redirect(redirect), .pc_stall(pc_a), .if_id_stall(ifid_a), .id_ex_bubble(bub_a),
    .ex_mem_stall(ems_a), .mem_wb_bubble(mwb_a), .if_id_flush(f1_a), .id_ex_flush(f2_a),
    .ex_mem_flush(f3_a), .fwd_a(fa_a), .fwd_b(fb_a), .mem_err(err_a),
    .stall_cnt(sc_a), .flush_cnt(fc_a));

  mips_hazard_unit #(.REG_AW(5), .LU_STALL_CYC(3), .MEM_TIMEOUT(16), .CNT_W(16)) u_dut_b (
    .clk_CPU(clk), .rst_CPU(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .mem_req(mem_req), .mem_ready(mem_ready),
    .redirect(redirect), .pc_stall(pc_b), .if_id_stall(ifid_b), .id_ex_bubble(bub_b),
    .ex_mem_stall(ems_b), .mem_wb_bubble(mwb_b), .if_id_flush(f1_b), .id_ex_flush(f2_b),
    .ex_mem_flush(f3_b), .fwd_a(fa_b), .fwd_b(fb_b), .mem_err(err_b),
    .stall_cnt(sc_b), .flush_cnt(fc_b));

  localparam int TIMEOUT = 16;
  int lu_len [2] = '{1, 3};
  int cnt_max[2] = '{3, 65535};

  // Model: bubbles still owed, whether a memory access is held and for how many stall cycles so far
  int bl[2], wc[2], sc[2], fc[2];
  bit wt[2], err[2];
  int n_bl[2], n_wc[2], n_sc[2], n_fc[2];
  bit n_wt[2], n_err[2];
  bit e_mem[2], e_fl[2], e_bub[2];

  int checks = 0;
  int errors = 0;

  function automatic int fwd_ref(input logic [4:0] src);
    if (mem_regwrite && mem_rd != 5'd0 && mem_rd == src) return 2;
    if (wb_regwrite && wb_rd != 5'd0 && wb_rd == src) return 1;
    return 0;
  endfunction

  function automatic bit lu_ref();
    return ex_memread && ex_rd != 5'd0 &&
           ((id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic free_events(input int i, input bit allow_mem);
    if (allow_mem && mem_req && !mem_ready) begin
      e_mem[i] = 1'b1; n_wt[i] = 1'b1; n_wc[i] = 1;
    end else if (redirect) begin
      e_fl[i] = 1'b1;
    end else if (lu_ref()) begin
      e_bub[i] = 1'b1; n_bl[i] = lu_len[i] - 1;
    end
  endtask

  task automatic model_eval();
    for (int i = 0; i < 2; i++) begin
      e_mem[i] = 1'b0; e_fl[i] = 1'b0; e_bub[i] = 1'b0;
      n_bl[i] = bl[i]; n_wt[i] = wt[i]; n_wc[i] = wc[i]; n_err[i] = err[i];
      if (rst) begin
        n_bl[i] = 0; n_wt[i] = 1'b0; n_wc[i] = 0; n_err[i] = 1'b0; n_sc[i] = 0; n_fc[i] = 0;
      end else begin
        if (wt[i]) begin
          if (mem_ready || wc[i] == TIMEOUT) begin
            n_wt[i] = 1'b0;
            if (!mem_ready) n_err[i] = 1'b1;
            free_events(i, 1'b0);
          end else begin
            e_mem[i] = 1'b1; n_wc[i] = wc[i] + 1;
          end
        end else if (bl[i] > 0) begin
          if (mem_req && !mem_ready) begin
            e_mem[i] = 1'b1; n_wt[i] = 1'b1; n_wc[i] = 1; n_bl[i] = 0;
          end else if (redirect) begin
            e_fl[i] = 1'b1; n_bl[i] = 0;
          end else begin
            e_bub[i] = 1'b1; n_bl[i] = bl[i] - 1;
          end
        end else begin
          free_events(i, 1'b1);
        end
        n_sc[i] = (e_mem[i] || e_bub[i]) ? ((sc[i] < cnt_max[i]) ? sc[i] + 1 : sc[i]) : sc[i];
        n_fc[i] = e_fl[i] ? ((fc[i] < cnt_max[i]) ? fc[i] + 1 : fc[i]) : fc[i];
      end
    end
  endtask

  function automatic logic [12:0] expvec(input int i);
    logic st;
    logic [1:0] fa, fb;
    if (rst) return 13'd0;
    st = e_mem[i] | e_bub[i];
    fa = 2'(fwd_ref(ex_rs));
    fb = 2'(fwd_ref(ex_rt));
    return {st, st, e_bub[i], e_mem[i], e_mem[i], e_fl[i], e_fl[i], e_fl[i], fa, fb, err[i]};
  endfunction

  task automatic compare();
    chk("ctl_a", 32'({pc_a, ifid_a, bub_a, ems_a, mwb_a, f1_a, f2_a, f3_a, fa_a, fb_a, err_a}),
        32'(expvec(0)));
    chk("stallcnt_a", 32'(sc_a), 32'(sc[0]));
    chk("flushcnt_a", 32'(fc_a), 32'(fc[0]));
    chk("ctl_b", 32'({pc_b, ifid_b, bub_b, ems_b, mwb_b, f1_b, f2_b, f3_b, fa_b, fb_b, err_b}),
        32'(expvec(1)));
    chk("stallcnt_b", 32'(sc_b), 32'(sc[1]));
    chk("flushcnt_b", 32'(fc_b), 32'(fc[1]));
  endtask

  task automatic commit();
    for (int i = 0; i < 2; i++) begin
      bl[i] = n_bl[i]; wt[i] = n_wt[i]; wc[i] = n_wc[i];
      err[i] = n_err[i]; sc[i] = n_sc[i]; fc[i] = n_fc[i];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      bl[i] = 0; wt[i] = 1'b0; wc[i] = 0; err[i] = 1'b0; sc[i] = 0; fc[i] = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_eval();
    compare();
    @(posedge clk);
    commit();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd} = '0;
    {id_uses_rs, id_uses_rt, ex_memread, mem_regwrite, wb_regwrite} = '0;
    {mem_req, mem_ready, redirect} = '0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;

    // Load-use hazard for one cycle: 1 bubble on a, 3 on b
    ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    tick();
    ex_memread = 1'b0;
    repeat (4) tick();
    chk("lu_stall_cnt_a", 32'(sc_a), 32'd1);
    chk("lu_stall_cnt_b", 32'(sc_b), 32'd3);

    // Load to r0 is never a hazard
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
    repeat (2) tick();
    ex_memread = 1'b0; id_uses_rs = 1'b0;
    chk("r0_no_stall_a", 32'(sc_a), 32'd1);

    // Forwarding priority
    mem_rd = 5'd9; wb_rd = 5'd9; mem_regwrite = 1'b1; wb_regwrite = 1'b1; ex_rs = 5'd9; ex_rt = 5'd0;
    tick();
    chk("fwd_mem_wins", 32'(fa_a), 32'd2);
    chk("fwd_r0", 32'(fb_a), 32'd0);
    mem_regwrite = 1'b0;
    tick();
    chk("fwd_wb", 32'(fa_b), 32'd1);
    wb_regwrite = 1'b0;

    // Memory wait of 4 cycles then ready
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (4) tick();
    mem_ready = 1'b1;
    tick();
    mem_req = 1'b0; mem_ready = 1'b0;
    tick();
    chk("memwait_cnt_b", 32'(sc_b), 32'd7);
    chk("memwait_cnt_a_sat", 32'(sc_a), 32'd3);
    chk("memwait_no_err", 32'(err_b), 32'd0);

    // Memory never ready: release after 16 stall cycles, sticky error
    mem_req = 1'b1;
    repeat (17) tick();
    mem_req = 1'b0;
    repeat (2) tick();
    chk("timeout_err", 32'(err_a), 32'd1);
    chk("timeout_stall_b", 32'(sc_b), 32'd23);

    // Redirect while b is in its load-use stall
    ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    tick();
    ex_memread = 1'b0; redirect = 1'b1;
    tick();
    redirect = 1'b0;
    repeat (2) tick();
    chk("lu_redirect_fc_b", 32'(fc_b), 32'd1);
    chk("lu_redirect_sc_b", 32'(sc_b), 32'd24);

    // Five redirects: 2-bit counter saturates
    redirect = 1'b1;
    repeat (5) tick();
    redirect = 1'b0;
    tick();
    chk("flush_sat_a", 32'(fc_a), 32'd3);
    chk("flush_cnt_b", 32'(fc_b), 32'd6);

    // Random traffic against the model
    repeat (400) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom_range(0, 1)); id_uses_rt = 1'($urandom_range(0, 1));
      ex_memread = 1'($urandom_range(0, 1));
      mem_regwrite = 1'($urandom_range(0, 1)); wb_regwrite = 1'($urandom_range(0, 1));
      mem_req = ($urandom_range(0, 3) == 0);
      mem_ready = 1'($urandom_range(0, 1));
      redirect = !mem_req && ($urandom_range(0, 5) == 0);
      tick();
    end

    // Asynchronous reset in the middle of a memory wait
    redirect = 1'b0; ex_memread = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
    mem_regwrite = 1'b1; mem_rd = 5'd9; ex_rs = 5'd9;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("async_ctl_a", 32'({pc_a, ifid_a, bub_a, ems_a, mwb_a, f1_a, fa_a, fb_a, err_a}), 32'd0);
    chk("async_ctl_b", 32'({pc_b, ems_b, mwb_b, fa_b, err_b}), 32'd0);
    chk("async_cnt_b", 32'({sc_b, fc_b}), 32'd0);
    chk("async_cnt_a", 32'({sc_a, fc_a}), 32'd0);
    model_reset();
    tick();
    rst = 1'b0; mem_req = 1'b0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
